// File: rtl/cp0_defs_pkg.sv
// Shared CP0 definitions: register addresses, ExcCodes, exception-type codes, bit positions.
// No logic; latency n/a.
// Backpressure: n/a.
package cp0_defs;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST = 32'h0040_0000;
    localparam int          EXCT_W     = 5;

    // {reg[4:0], sel[2:0]}; only sel=0 is mapped
    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [EXCT_W-1:0] EXCT_NONE  = 5'd0;
    localparam logic [EXCT_W-1:0] EXCT_INTR  = 5'd1;
    localparam logic [EXCT_W-1:0] EXCT_ADEL1 = 5'd2;
    localparam logic [EXCT_W-1:0] EXCT_ADEL2 = 5'd3;
    localparam logic [EXCT_W-1:0] EXCT_ADES  = 5'd4;
    localparam logic [EXCT_W-1:0] EXCT_SYSC  = 5'd5;
    localparam logic [EXCT_W-1:0] EXCT_BP    = 5'd6;
    localparam logic [EXCT_W-1:0] EXCT_RI    = 5'd7;
    localparam logic [EXCT_W-1:0] EXCT_OV    = 5'd8;
    localparam logic [EXCT_W-1:0] EXCT_ERET  = 5'd9;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_BEV = 22;
    localparam int CA_BD  = 31;
    localparam int CA_TI  = 30;

    function automatic logic [4:0] exccode_of(input logic [EXCT_W-1:0] t);
        logic [4:0] c;
        c = EXC_INT;
        case (t)
            EXCT_ADEL1, EXCT_ADEL2: c = EXC_ADEL;
            EXCT_ADES:              c = EXC_ADES;
            EXCT_SYSC:              c = EXC_SYS;
            EXCT_BP:                c = EXC_BP;
            EXCT_RI:                c = EXC_RI;
            EXCT_OV:                c = EXC_OV;
            default:                c = EXC_INT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, TI latches when Count steps onto Compare.
// Latency: writes and TI updates visible one clock after the edge.
// Backpressure: none; writes always accepted.
module cp0_timer
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    input  logic        ti_clr,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        tick;
    logic [31:0] count_inc;

    assign count_inc = count + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            tick    <= 1'b0;
            ti      <= 1'b0;
        end else begin
            if (count_wen) begin
                count <= wdata;
                tick  <= 1'b0;
            end else begin
                tick <= ~tick;
                if (tick)
                    count <= count_inc;
            end
            if (compare_wen)
                compare <= wdata;
            // Clear beats a match arriving on the same edge
            if (ti_clr)
                ti <= 1'b0;
            else if (tick && !count_wen && count_inc == compare)
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regs.sv
// CP0 register file and exception-state controller (BadVAddr/Count/Compare/Status/Cause/EPC).
// Latency: MFC0 reads and flush target combinational; MTC0 and commits take effect next edge.
// Backpressure: none; a commit in the same cycle discards the MTC0.
module cp0_regs
    import cp0_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cp0_wen_i,
    input  logic [7:0]        cp0_waddr_i,
    input  logic [31:0]       cp0_wdata_i,
    input  logic [7:0]        cp0_raddr_i,
    output logic [31:0]       cp0_rdata_o,
    input  logic              exc_flag_i,
    input  logic [EXCT_W-1:0] exc_type_i,
    input  logic [31:0]       exc_pc_i,
    input  logic              exc_bd_i,
    input  logic [31:0]       exc_baddr_i,
    input  logic [5:0]        intr_hw_i,
    output logic [31:0]       Status_o,
    output logic [31:0]       Cause_o,
    output logic [31:0]       EPC_o,
    output logic              intr_o,
    output logic [31:0]       flush_pc_o
);

    logic [7:0]  im;
    logic        exl, ie;
    logic [1:0]  ip_sw;
    logic [5:0]  ip_hw;
    logic [4:0]  exc_code;
    logic        bd;
    logic [31:0] epc, badvaddr;
    logic [31:0] count, compare;
    logic        ti;
    logic        wr, is_eret, is_exc, is_addr_exc;

    assign wr          = cp0_wen_i & ~exc_flag_i;
    assign is_eret     = exc_flag_i && exc_type_i == EXCT_ERET;
    assign is_exc      = exc_flag_i && exc_type_i != EXCT_ERET;
    assign is_addr_exc = exc_type_i == EXCT_ADEL1 || exc_type_i == EXCT_ADEL2
                      || exc_type_i == EXCT_ADES;

    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_wen   (wr && cp0_waddr_i == CP0_COUNT),
        .compare_wen (wr && cp0_waddr_i == CP0_COMPARE),
        .wdata       (cp0_wdata_i),
        .ti_clr      (wr && cp0_waddr_i == CP0_COMPARE),
        .count       (count),
        .compare     (compare),
        .ti          (ti)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            ip_sw    <= '0;
            ip_hw    <= '0;
            exc_code <= '0;
            bd       <= 1'b0;
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            ip_hw <= intr_hw_i;
            if (is_exc) begin
                exc_code <= exccode_of(exc_type_i);
                // Nested exception keeps the original return point
                if (!exl) begin
                    epc <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                    bd  <= exc_bd_i;
                end
                exl <= 1'b1;
                if (is_addr_exc)
                    badvaddr <= exc_baddr_i;
            end else if (is_eret) begin
                exl <= 1'b0;
            end else if (wr) begin
                case (cp0_waddr_i)
                    CP0_STATUS: begin
                        im  <= cp0_wdata_i[15:8];
                        exl <= cp0_wdata_i[ST_EXL];
                        ie  <= cp0_wdata_i[ST_IE];
                    end
                    CP0_CAUSE: ip_sw <= cp0_wdata_i[9:8];
                    CP0_EPC:   epc   <= cp0_wdata_i;
                    default: ;
                endcase
            end
        end
    end

    assign Status_o = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign Cause_o  = {bd, ti, 14'b0, ip_hw[5] | ti, ip_hw[4:0], ip_sw, 1'b0, exc_code, 2'b0};
    assign EPC_o    = epc;

    assign intr_o     = (|(Cause_o[15:8] & im)) & ie & ~exl;
    assign flush_pc_o = (exc_type_i == EXCT_ERET) ? epc : EXC_VECTOR;

    always_comb begin
        cp0_rdata_o = '0;
        case (cp0_raddr_i)
            CP0_BADVADDR: cp0_rdata_o = badvaddr;
            CP0_COUNT:    cp0_rdata_o = count;
            CP0_COMPARE:  cp0_rdata_o = compare;
            CP0_STATUS:   cp0_rdata_o = Status_o;
            CP0_CAUSE:    cp0_rdata_o = Cause_o;
            CP0_EPC:      cp0_rdata_o = epc;
            default:      cp0_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Bench for cp0_regs: directed vectors with literal expectations, plus a per-cycle
// comparison against a field-level behavioural model of the CP0 state.
module tb_cp0_regs;
    import cp0_defs::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cp0_wen = 1'b0;
    logic [7:0]        cp0_waddr = '0;
    logic [31:0]       cp0_wdata = '0;
    logic [7:0]        cp0_raddr = '0;
    logic [31:0]       cp0_rdata;
    logic              exc_flag = 1'b0;
    logic [EXCT_W-1:0] exc_type = '0;
    logic [31:0]       exc_pc = '0;
    logic              exc_bd = 1'b0;
    logic [31:0]       exc_baddr = '0;
    logic [5:0]        intr_hw = '0;
    logic [31:0]       status_w, cause_w, epc_w, flush_pc;
    logic              intr;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    cp0_regs dut (
        .clk         (clk),
        .rst         (rst),
        .cp0_wen_i   (cp0_wen),
        .cp0_waddr_i (cp0_waddr),
        .cp0_wdata_i (cp0_wdata),
        .cp0_raddr_i (cp0_raddr),
        .cp0_rdata_o (cp0_rdata),
        .exc_flag_i  (exc_flag),
        .exc_type_i  (exc_type),
        .exc_pc_i    (exc_pc),
        .exc_bd_i    (exc_bd),
        .exc_baddr_i (exc_baddr),
        .intr_hw_i   (intr_hw),
        .Status_o    (status_w),
        .Cause_o     (cause_w),
        .EPC_o       (epc_w),
        .intr_o      (intr),
        .flush_pc_o  (flush_pc)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_phase;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_hw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_badv, m_count, m_compare;

    function automatic logic [4:0] m_code(input logic [EXCT_W-1:0] t);
        if (t == EXCT_ADEL1 || t == EXCT_ADEL2) return 5'h04;
        if (t == EXCT_ADES) return 5'h05;
        if (t == EXCT_SYSC) return 5'h08;
        if (t == EXCT_BP)   return 5'h09;
        if (t == EXCT_RI)   return 5'h0A;
        if (t == EXCT_OV)   return 5'h0C;
        return 5'h00;
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        logic [7:0] ip;
        ip = {m_hw[5] | m_ti, m_hw[4:0], m_ipsw};
        return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(ip) << 8) | (32'(m_exc) << 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h40:   return m_badv;
            8'h48:   return m_count;
            8'h58:   return m_compare;
            8'h60:   return m_status();
            8'h68:   return m_cause();
            8'h70:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_phase = 0;
            m_ipsw = 0; m_hw = 0; m_exc = 0;
            m_epc = 0; m_badv = 0; m_count = 0; m_compare = 0;
        end else begin
            logic w;
            w = cp0_wen && !exc_flag;
            if (w && cp0_waddr == 8'h48) begin
                m_count = cp0_wdata;
                m_phase = 0;
            end else begin
                if (m_phase) begin
                    m_count = m_count + 1;
                    if (m_count == m_compare) m_ti = 1;
                end
                m_phase = !m_phase;
            end
            if (w && cp0_waddr == 8'h58) begin
                m_compare = cp0_wdata;
                m_ti = 0;
            end
            m_hw = intr_hw;
            if (exc_flag && exc_type == EXCT_ERET) begin
                m_exl = 0;
            end else if (exc_flag) begin
                m_exc = m_code(exc_type);
                if (!m_exl) begin
                    m_epc = exc_pc - (exc_bd ? 32'd4 : 32'd0);
                    m_bd = exc_bd;
                end
                m_exl = 1;
                if (exc_type == EXCT_ADEL1 || exc_type == EXCT_ADEL2 || exc_type == EXCT_ADES)
                    m_badv = exc_baddr;
            end else if (w) begin
                if (cp0_waddr == 8'h60) begin
                    m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
                end
                if (cp0_waddr == 8'h68) m_ipsw = cp0_wdata[9:8];
                if (cp0_waddr == 8'h70) m_epc = cp0_wdata;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model Status_o", status_w, m_status());
            chk("model Cause_o", cause_w, m_cause());
            chk("model EPC_o", epc_w, m_epc);
            chk("model rdata", cp0_rdata, m_read(cp0_raddr));
            chk("model intr_o", 32'(intr),
                32'((|(m_cause() >> 8 & 32'hFF & 32'(m_im))) && m_ie && !m_exl));
            if (exc_flag)
                chk("model flush_pc", flush_pc,
                    (exc_type == EXCT_ERET) ? m_epc : 32'hBFC0_0380);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        cp0_wen = 1; cp0_waddr = a; cp0_wdata = d;
        @(posedge clk); #1;
        cp0_wen = 0;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        cp0_raddr = a;
        #1;
        chk(name, cp0_rdata, exp);
    endtask

    task automatic commit(input logic [EXCT_W-1:0] t, input logic [31:0] pc, input logic b,
                          input logic [31:0] ba, input logic [31:0] exp_flush);
        exc_flag = 1; exc_type = t; exc_pc = pc; exc_bd = b; exc_baddr = ba;
        #1;
        chk("flush_pc", flush_pc, exp_flush);
        @(posedge clk); #1;
        exc_flag = 0; exc_type = EXCT_NONE;
    endtask

    initial begin
        #2 rst = 1;
        #6 chk_en = 1;
        chk("reset Status", status_w, 32'h0040_0000);
        chk("reset Cause", cause_w, 32'h0);
        chk("reset EPC", epc_w, 32'h0);
        rd("reset MFC0 Status", 8'h60, 32'h0040_0000);
        @(posedge clk); #1;
        rst = 0;

        mtc0(8'h60, 32'hFFFF_FFFF);
        rd("Status masked write", 8'h60, 32'h0040_FF03);
        mtc0(8'h60, 32'h0);

        commit(EXCT_ADEL2, 32'h8000_0100, 1'b1, 32'h3, 32'hBFC0_0380);
        chk("AdEL2 EPC", epc_w, 32'h8000_00FC);
        chk("AdEL2 BD", 32'(cause_w[31]), 32'h1);
        chk("AdEL2 ExcCode", 32'(cause_w[6:2]), 32'h04);
        chk("AdEL2 EXL", 32'(status_w[1]), 32'h1);
        rd("AdEL2 BadVAddr", 8'h40, 32'h3);

        commit(EXCT_OV, 32'h8000_0200, 1'b0, 32'h77, 32'hBFC0_0380);
        chk("nested EPC", epc_w, 32'h8000_00FC);
        chk("nested ExcCode", 32'(cause_w[6:2]), 32'h0C);
        rd("Ov BadVAddr kept", 8'h40, 32'h3);

        commit(EXCT_ERET, 32'h0, 1'b0, 32'h0, 32'h8000_00FC);
        chk("ERET EXL", 32'(status_w[1]), 32'h0);

        mtc0(8'h60, 32'h0000_8001);
        mtc0(8'h58, 32'd5);
        mtc0(8'h48, 32'd0);
        repeat (9) @(posedge clk);
        #1;
        chk("TI before match", 32'(cause_w[30]), 32'h0);
        rd("Count after 9", 8'h48, 32'd4);
        @(posedge clk); #1;
        chk("TI at match", 32'(cause_w[30]), 32'h1);
        chk("timer intr_o", 32'(intr), 32'h1);
        mtc0(8'h58, 32'd100);
        chk("TI cleared", 32'(cause_w[30]), 32'h0);
        chk("intr_o cleared", 32'(intr), 32'h0);

        mtc0(8'h60, 32'h0000_1001);
        intr_hw = 6'b000100;
        @(posedge clk); #1;
        chk("hw IP12", 32'(cause_w[15:8]), 32'h10);
        chk("hw intr_o", 32'(intr), 32'h1);
        intr_hw = 6'b0;
        @(posedge clk); #1;
        chk("hw intr_o low", 32'(intr), 32'h0);

        mtc0(8'h68, 32'hFFFF_FFFF);
        chk("Cause masked write", cause_w, 32'h8000_0330);
        mtc0(8'h60, 32'h0000_0101);
        chk("sw intr_o", 32'(intr), 32'h1);
        mtc0(8'h68, 32'h0);

        cp0_wen = 1; cp0_waddr = 8'h70; cp0_wdata = 32'h1234;
        commit(EXCT_SYSC, 32'h8000_0300, 1'b0, 32'h0, 32'hBFC0_0380);
        cp0_wen = 0;
        chk("commit wins EPC", epc_w, 32'h8000_0300);
        chk("SysC ExcCode", 32'(cause_w[6:2]), 32'h08);

        mtc0({5'd14, 3'd1}, 32'hDEAD_BEEF);
        chk("sel1 write ignored", epc_w, 32'h8000_0300);
        rd("sel1 read", {5'd12, 3'd1}, 32'h0);
        rd("unmapped read", 8'h00, 32'h0);
        mtc0(8'h70, 32'h0000_1234);
        rd("EPC write", 8'h70, 32'h0000_1234);
        mtc0(8'h60, 32'h0000_0000);

        mtc0(8'h58, 32'd7);
        mtc0(8'h48, 32'hFFFF_FFFF);
        rd("Count loaded", 8'h48, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rd("Count held", 8'h48, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rd("Count wrap", 8'h48, 32'h0);
        chk("wrap TI", 32'(cause_w[30]), 32'h0);

        mtc0(8'h60, 32'h0000_FF03);
        mtc0(8'h48, 32'hFFFF_FFFF);
        cp0_raddr = 8'h48;
        exc_flag = 1; exc_type = EXCT_SYSC; exc_pc = 32'h8000_0400;
        #2 rst = 1;
        #1;
        chk("async Status", status_w, 32'h0040_0000);
        chk("async Cause", cause_w, 32'h0);
        chk("async EPC", epc_w, 32'h0);
        chk("async Count", cp0_rdata, 32'h0);
        rd("async Compare", 8'h58, 32'h0);
        rd("async BadVAddr", 8'h40, 32'h0);
        exc_flag = 0; exc_type = EXCT_NONE;
        #1 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("post-reset EPC", epc_w, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_regs.md
Name: cp0_regs

Overview:
- Coprocessor-0 register file and exception-state controller for the core.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC, and serves MFC0/MTC0 accesses from the pipeline.
- Commits exceptions and ERET reported by the exception classifier, and produces the masked interrupt vector and flush target.
- Sits beside the memory stage; its Status/Cause/EPC outputs feed the exception classifier in the same cycle.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, flush target for every exception except ERET
STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, all else 0)
EXCT_W, 5, width of the exception-type code (shared ExcT width)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
cp0_wen_i  in  1  MTC0 write strobe
cp0_waddr_i  in  8  {reg[4:0], sel[2:0]}
cp0_wdata_i  in  32  MTC0 data
cp0_raddr_i  in  8  MFC0 address
cp0_rdata_o  out  32  MFC0 data (combinational)
exc_flag_i  in  1  exception/ERET commit this cycle
exc_type_i  in  EXCT_W  committed exception type
exc_pc_i  in  32  PC of faulting instruction
exc_bd_i  in  1  faulting instruction is in a delay slot
exc_baddr_i  in  32  bad address for AdEL/AdES
intr_hw_i  in  6  external interrupt lines, level-sensitive
Status_o  out  32  current Status
Cause_o  out  32  current Cause
EPC_o  out  32  current EPC
intr_o  out  1  interrupt pending and enabled
flush_pc_o  out  32  EPC if exc_type_i==ERET else EXC_VECTOR

Behaviour:
- Reset (async): Status=STATUS_RST; Cause=0; EPC=0; BadVAddr=0; Count=0; Compare=0; tick toggle=0.
  - All outputs reflect these values.
  - Reset mid-operation abandons any commit in flight.
- Register map, sel=0 only:
  - 8 BadVAddr: read-only.
  - 9 Count: read/write.
  - 11 Compare: read/write.
  - 12 Status: writable IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; other bits read 0.
  - 13 Cause: writable IP[9:8] only.
  - 14 EPC: read/write.
- Unmapped address or sel!=0: reads 0, writes ignored.
- Reads are combinational from current register state. A same-cycle write is not bypassed; pipeline forwarding covers that case.
- Writes take effect at the next rising edge.
- Count/timer:
  - Count increments on every second clock via the tick toggle.
  - An MTC0 to Count loads the value and clears the toggle.
  - TI (Cause[30]) is set on the edge where Count==Compare.
  - An MTC0 to Compare clears TI; this wins over a simultaneous match.
- Cause.IP[15:10] is sampled every cycle from intr_hw_i; IP[15] is ORed with TI.
- intr_o = |(Cause.IP[15:8] & Status.IM[15:8]) & Status.IE & ~Status.EXL.
- Exception commit (exc_flag_i=1, type != ERET):
  - ExcCode written to Cause[6:2]: Intr=0x00, AdEL1/AdEL2=0x04, AdES=0x05, SysC=0x08, Bp=0x09, RI=0x0A, Ov=0x0C.
  - If EXL was 0: EPC = exc_bd_i ? exc_pc_i-4 : exc_pc_i, and Cause.BD = exc_bd_i.
  - If EXL was already 1: EPC and BD are unchanged.
  - EXL is set to 1.
  - BadVAddr = exc_baddr_i for AdEL1/AdEL2/AdES only.
- ERET commit: EXL cleared; Cause, EPC and BadVAddr unchanged.
- Simultaneous MTC0 and commit in one cycle: the commit wins for Status, Cause, EPC and BadVAddr, and the MTC0 is discarded entirely.
- The timer and hardware IP sampling proceed regardless of commits.
- flush_pc_o is combinational, valid whenever exc_flag_i=1.
- Count wraps 32'hFFFF_FFFF to 0 with no side effect.

Decomposition:
- Shared package cp0_defs:
  - CP0 register address constants.
  - ExcCode constants.
  - ExcT type codes and EXCT_W.
  - Status/Cause bit-position constants.
- One sub-module, cp0_timer: Count, Compare, tick toggle and TI, with write ports and a TI-clear input.

Test Plan:
- Reset, then MFC0 reg12 -> 32'h0040_0000. Then MTC0 reg12=32'hFFFF_FFFF and read -> 32'h0040_FF03.
- Commit AdEL2, exc_pc_i=32'h8000_0100, bd=1, baddr=32'h0000_0003:
  - Next cycle: EPC=32'h8000_00FC, Cause[31]=1, Cause[6:2]=0x04, BadVAddr=32'h3, EXL=1, flush_pc_o=32'hBFC0_0380.
- With EXL=1, commit Ov at pc 32'h8000_0200 -> EPC stays 32'h8000_00FC, ExcCode=0x0C. Then ERET -> EXL=0, flush_pc_o=EPC.
- Compare=5, Count=0: TI set after 10 clocks. With IM7=1, IE=1, EXL=0 -> intr_o=1. MTC0 Compare -> TI=0, intr_o=0 next cycle.
- Same-cycle MTC0 EPC=32'h1234 and SysC commit at pc 32'h8000_0300 -> EPC=32'h8000_0300, ExcCode=0x08.
- Assert rst mid-count with Count=32'hFFFF_FFFF -> all registers return to reset values immediately, without waiting for a clock edge. A separate run with Count=32'hFFFF_FFFF and no reset -> Count wraps to 0.
